// File: rtl/conv3x3_pkg.sv
// Shared types and constants for the 3x3 convolution engine.
// Sobel kernels, identity kernel, mode encoding, accumulator sizing.
package conv3x3_pkg;

  typedef enum logic [1:0] {
    MODE_SOBEL = 2'd0,
    MODE_GX    = 2'd1,
    MODE_GY    = 2'd2,
    MODE_USER  = 2'd3
  } mode_e;

  localparam int NTAP = 9;

  localparam logic signed [3:0] SOBEL_GX [NTAP] = '{
    -4'sd1, 4'sd0, 4'sd1,
    -4'sd2, 4'sd0, 4'sd2,
    -4'sd1, 4'sd0, 4'sd1
  };

  localparam logic signed [3:0] SOBEL_GY [NTAP] = '{
    -4'sd1, -4'sd2, -4'sd1,
     4'sd0,  4'sd0,  4'sd0,
     4'sd1,  4'sd2,  4'sd1
  };

  localparam logic signed [3:0] ID_K [NTAP] = '{
    4'sd0, 4'sd0, 4'sd0,
    4'sd0, 4'sd1, 4'sd0,
    4'sd0, 4'sd0, 4'sd0
  };

  function automatic int acc_width(input int pw, input int cw);
    return pw + cw + 4;
  endfunction

endpackage

// File: rtl/conv3x3_engine_if.sv
// Window-in / result-out handshake bundle plus coefficient write port.
// master drives windows and consumes results; slave is the engine.
interface conv3x3_engine_if #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
);
  logic [9*PIX_W-1:0] i_pixel_data;
  logic               i_pixel_data_valid;
  logic               o_pixel_data_ready;
  logic [1:0]         i_mode;
  logic [3:0]         i_shift;
  logic               i_coef_wr;
  logic [3:0]         i_coef_addr;
  logic [COEF_W-1:0]  i_coef_data;
  logic [PIX_W-1:0]   o_convolved_data;
  logic               o_convolved_data_valid;
  logic               i_convolved_data_ready;

  modport master (
    output i_pixel_data, i_pixel_data_valid,
    output i_mode, i_shift,
    output i_coef_wr, i_coef_addr, i_coef_data,
    output i_convolved_data_ready,
    input  o_pixel_data_ready,
    input  o_convolved_data, o_convolved_data_valid
  );

  modport slave (
    input  i_pixel_data, i_pixel_data_valid,
    input  i_mode, i_shift,
    input  i_coef_wr, i_coef_addr, i_coef_data,
    input  i_convolved_data_ready,
    output o_pixel_data_ready,
    output o_convolved_data, o_convolved_data_valid
  );
endinterface

// File: rtl/conv3x3_post.sv
// Stage-3 post-processing: abs/sum/saturate for Sobel modes,
// arithmetic shift and clamp for the user kernel.
module conv3x3_post
  import conv3x3_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0] sum_a_i,
  input  logic signed [ACC_W-1:0] sum_b_i,
  input  mode_e                   mode_i,
  input  logic [3:0]              shift_i,
  output logic [PIX_W-1:0]        pix_o
);

  logic [ACC_W-1:0]        abs_a;
  logic [ACC_W-1:0]        abs_b;
  logic signed [ACC_W-1:0] shd;
  logic [ACC_W:0]          mag;

  assign abs_a = sum_a_i[ACC_W-1] ? -sum_a_i : sum_a_i;
  assign abs_b = sum_b_i[ACC_W-1] ? -sum_b_i : sum_b_i;
  assign shd   = sum_a_i >>> shift_i;

  // Non-negative magnitude per mode, then saturate to pixel range
  always_comb begin
    mag = '0;
    case (mode_i)
      MODE_SOBEL: mag = {1'b0, abs_a} + {1'b0, abs_b};
      MODE_USER:  mag = shd[ACC_W-1] ? '0 : {1'b0, shd};
      default:    mag = {1'b0, abs_a};
    endcase
    pix_o = (|mag[ACC_W:PIX_W]) ? '1 : mag[PIX_W-1:0];
  end

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine: multiply, sum, post-process pipeline
// with a single global stall driven by the output handshake.
module conv3x3_engine
  import conv3x3_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
) (
  input logic          i_clk,
  input logic          i_rst,
  conv3x3_engine_if.slave bus
);

  localparam int ACC_W = acc_width(PIX_W, COEF_W);
  typedef logic signed [ACC_W-1:0] acc_t;

  logic                     en;
  mode_e                    mode_in;
  logic signed [COEF_W-1:0] coef_q [NTAP];
  acc_t                     ka [NTAP];
  acc_t                     kb [NTAP];
  acc_t                     pa_d [NTAP];
  acc_t                     pb_d [NTAP];
  acc_t                     s1_pa_q [NTAP];
  acc_t                     s1_pb_q [NTAP];
  logic                     s1_vld_q;
  mode_e                    s1_mode_q;
  logic [3:0]               s1_shift_q;
  acc_t                     sa_d;
  acc_t                     sb_d;
  acc_t                     s2_sa_q;
  acc_t                     s2_sb_q;
  logic                     s2_vld_q;
  mode_e                    s2_mode_q;
  logic [3:0]               s2_shift_q;
  logic [PIX_W-1:0]         post_d;
  logic [PIX_W-1:0]         out_q;
  logic                     out_vld_q;

  assign en      = !out_vld_q || bus.i_convolved_data_ready;
  assign mode_in = mode_e'(bus.i_mode);

  assign bus.o_pixel_data_ready     = en;
  assign bus.o_convolved_data       = out_q;
  assign bus.o_convolved_data_valid = out_vld_q;

  // Kernel pick per incoming mode and per-tap products
  always_comb begin
    for (int k = 0; k < NTAP; k++) begin
      ka[k] = acc_t'(SOBEL_GX[k]);
      kb[k] = acc_t'(SOBEL_GY[k]);
      case (mode_in)
        MODE_GY:   ka[k] = acc_t'(SOBEL_GY[k]);
        MODE_USER: ka[k] = acc_t'(coef_q[k]);
        default:   ka[k] = acc_t'(SOBEL_GX[k]);
      endcase
      pa_d[k] = ka[k] *
        acc_t'({1'b0, bus.i_pixel_data[k*PIX_W +: PIX_W]});
      pb_d[k] = kb[k] *
        acc_t'({1'b0, bus.i_pixel_data[k*PIX_W +: PIX_W]});
    end
  end

  // User coefficients, writable regardless of stall
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NTAP; k++)
        coef_q[k] <= COEF_W'(ID_K[k]);
    end else if (bus.i_coef_wr && bus.i_coef_addr <= 4'd8) begin
      coef_q[bus.i_coef_addr] <= bus.i_coef_data;
    end
  end

  // Stage 1: register products with the window's mode and shift
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld_q   <= 1'b0;
      s1_mode_q  <= MODE_SOBEL;
      s1_shift_q <= '0;
      for (int k = 0; k < NTAP; k++) begin
        s1_pa_q[k] <= '0;
        s1_pb_q[k] <= '0;
      end
    end else if (en) begin
      s1_vld_q   <= bus.i_pixel_data_valid;
      s1_mode_q  <= mode_in;
      s1_shift_q <= bus.i_shift;
      for (int k = 0; k < NTAP; k++) begin
        s1_pa_q[k] <= pa_d[k];
        s1_pb_q[k] <= pb_d[k];
      end
    end
  end

  // Adder tree over the nine products
  always_comb begin
    sa_d = '0;
    sb_d = '0;
    for (int k = 0; k < NTAP; k++) begin
      sa_d = sa_d + s1_pa_q[k];
      sb_d = sb_d + s1_pb_q[k];
    end
  end

  // Stage 2: register sums
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_vld_q   <= 1'b0;
      s2_mode_q  <= MODE_SOBEL;
      s2_shift_q <= '0;
      s2_sa_q    <= '0;
      s2_sb_q    <= '0;
    end else if (en) begin
      s2_vld_q   <= s1_vld_q;
      s2_mode_q  <= s1_mode_q;
      s2_shift_q <= s1_shift_q;
      s2_sa_q    <= sa_d;
      s2_sb_q    <= sb_d;
    end
  end

  conv3x3_post #(
    .PIX_W (PIX_W),
    .ACC_W (ACC_W)
  ) u_post (
    .sum_a_i (s2_sa_q),
    .sum_b_i (s2_sb_q),
    .mode_i  (s2_mode_q),
    .shift_i (s2_shift_q),
    .pix_o   (post_d)
  );

  // Stage 3: output register, held while downstream stalls
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (en) begin
      out_q     <= post_d;
      out_vld_q <= s2_vld_q;
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine: directed windows,
// a stalled random stream, coefficient timing and reset flush.
module tb_conv3x3_engine;

  localparam int PW = 8;
  localparam int CW = 8;

  typedef struct {
    int data;
    int t;
    bit lat;
  } exp_t;

  logic clk;
  logic rst;

  conv3x3_engine_if #(.PIX_W(PW), .COEF_W(CW)) bus();

  conv3x3_engine #(.PIX_W(PW), .COEF_W(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t ce;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   cf [9];
  bit   rand_rdy = 0;
  bit   hold = 0;
  int   hold_data = 0;
  int   GX [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int   GY [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] rows3(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [7:0] c);
    logic [71:0] w;
    for (int k = 0; k < 9; k++)
      w[k*8 +: 8] = (k % 3 == 0) ? a : ((k % 3 == 1) ? b : c);
    return w;
  endfunction

  function automatic logic [71:0] fill(input logic [7:0] v);
    return rows3(v, v, v);
  endfunction

  function automatic int model(input logic [71:0] w,
                               input logic [1:0] m, input int sh);
    int gx = 0, gy = 0, u = 0, p, v;
    for (int k = 0; k < 9; k++) begin
      p = int'(w[k*8 +: 8]);
      gx += GX[k] * p;
      gy += GY[k] * p;
      u  += cf[k] * p;
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    case (m)
      2'd0:    v = gx + gy;
      2'd1:    v = gx;
      2'd2:    v = gy;
      default: v = u >>> sh;
    endcase
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bus.i_convolved_data_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rst) begin
      hold = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", 32'(bus.o_convolved_data_valid), 1);
        chk("hold_data", 32'(bus.o_convolved_data), hold_data);
      end
      hold = 0;
      if (bus.o_convolved_data_valid) begin
        if (bus.i_convolved_data_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", sb.size(), 1);
          end else begin
            ce = sb.pop_front();
            chk("data", 32'(bus.o_convolved_data), ce.data);
            if (ce.lat) chk("latency", cyc - ce.t, 3);
          end
        end else begin
          hold = 1;
          hold_data = int'(bus.o_convolved_data);
        end
      end
    end
  end

  task automatic send(input logic [71:0] w, input logic [1:0] m,
                      input logic [3:0] sh, input int expv,
                      input bit lat, input bit wr = 0,
                      input logic [3:0] wa = 0, input int wd = 0);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    bus.i_pixel_data       = w;
    bus.i_pixel_data_valid = 1'b1;
    bus.i_mode             = m;
    bus.i_shift            = sh;
    #1;
    while (!bus.o_pixel_data_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      chk("accept_timeout", n, 0);
      bus.i_pixel_data_valid = 1'b0;
      return;
    end
    e.data = expv;
    e.t    = cyc;
    e.lat  = lat;
    sb.push_back(e);
    bus.i_coef_wr   = wr;
    bus.i_coef_addr = wa;
    bus.i_coef_data = 8'(wd);
    @(posedge clk);
    #1;
    bus.i_pixel_data_valid = 1'b0;
    bus.i_coef_wr          = 1'b0;
    if (wr && wa <= 8) cf[wa] = wd;
  endtask

  task automatic wr_coef(input logic [3:0] a, input int d);
    @(negedge clk);
    bus.i_coef_wr   = 1'b1;
    bus.i_coef_addr = a;
    bus.i_coef_data = 8'(d);
    @(posedge clk);
    #1;
    bus.i_coef_wr = 1'b0;
    if (a <= 8) cf[a] = d;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [71:0] w;
    logic [1:0]  m;
    logic [3:0]  sh;
    int          ev;
    rst = 1'b1;
    bus.i_pixel_data       = '0;
    bus.i_pixel_data_valid = 1'b0;
    bus.i_mode             = 2'd0;
    bus.i_shift            = 4'd0;
    bus.i_coef_wr          = 1'b0;
    bus.i_coef_addr        = 4'd0;
    bus.i_coef_data        = 8'd0;
    for (int k = 0; k < 9; k++) cf[k] = (k == 4) ? 1 : 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.o_convolved_data_valid), 0);
    chk("rst_data", 32'(bus.o_convolved_data), 0);
    chk("rst_ready", 32'(bus.o_pixel_data_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    send(rows3(0, 0, 255), 2'd0, 4'd0, 255, 1);
    send(rows3(10, 20, 30), 2'd1, 4'd0, 80, 1);
    send(rows3(10, 20, 30), 2'd2, 4'd0, 0, 1);
    drain();

    for (int k = 0; k < 9; k++) wr_coef(4'(k), 1);
    send(fill(8), 2'd3, 4'd3, 9, 1);
    wr_coef(4'd0, -100);
    send(fill(255), 2'd3, 4'd3, 0, 1);
    drain();

    for (int k = 0; k < 9; k++) wr_coef(4'(k), (k == 4) ? 1 : 0);
    wr_coef(4'd12, 50);
    wr_coef(4'd9, 7);
    send(fill(10), 2'd3, 4'd0, 10, 1, 1, 4'd4, 2);
    send(fill(10), 2'd3, 4'd0, 20, 1);
    drain();

    for (int k = 0; k < 9; k++)
      wr_coef(4'(k), $urandom_range(0, 16) - 8);
    rand_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      w  = {$urandom, $urandom, $urandom};
      m  = 2'($urandom_range(0, 3));
      sh = 4'($urandom_range(0, 7));
      ev = model(w, m, int'(sh));
      send(w, m, sh, ev, 0);
    end
    drain();
    rand_rdy = 0;
    repeat (2) @(negedge clk);

    wr_coef(4'd0, 5);
    send(fill(1), 2'd0, 4'd0, model(fill(1), 2'd0, 0), 0);
    send(fill(2), 2'd1, 4'd0, model(fill(2), 2'd1, 0), 0);
    send(fill(3), 2'd3, 4'd0, model(fill(3), 2'd3, 0), 0);
    chk("prerst_valid", 32'(bus.o_convolved_data_valid), 1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.o_convolved_data_valid), 0);
    chk("midrst_data", 32'(bus.o_convolved_data), 0);
    sb.delete();
    for (int k = 0; k < 9; k++) cf[k] = (k == 4) ? 1 : 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    w = fill(200);
    w[4*8 +: 8] = 8'd77;
    send(w, 2'd3, 4'd0, 77, 1);
    drain();
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
